bcd_deci_dec: RTL

Sequential BCD-to-decimal decoder: accepts a stream of 4-bit BCD digits over a valid/ready handshake and emits each as a 10-bit one-hot decimal line vector on a second valid/ready port. It is the inverse of the team's decimal-to-BCD priority encoder and sits on the display/keypad path where BCD digits must drive one-hot decimal lines. Non-BCD codes (10–15) are flagged and counted. A 2-entry output buffer decouples the producer from a stalling consumer.

---
 rtl/bcd_deci_dec_if.sv | 24 ++
 rtl/bcd_deci_dec.sv | 97 +++++++++
 2 files changed

// File: rtl/bcd_deci_dec_if.sv
// Handshake bundle for bcd_deci_dec.
//   in_valid / in_ready / bcd      : digit input stream
//   out_valid / out_ready / d / err : decoded one-hot output stream
// slave  : the decoder side
// master : the producer/consumer side (testbench or surrounding logic)
interface bcd_deci_dec_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] bcd;
  logic       out_valid;
  logic       out_ready;
  logic [9:0] d;
  logic       err;

  modport slave (
    input  in_valid, bcd, out_ready,
    output in_ready, out_valid, d, err
  );

  modport master (
    output in_valid, bcd, out_ready,
    input  in_ready, out_valid, d, err
  );
endinterface

// File: rtl/bcd_deci_dec.sv
// Sequential BCD-to-decimal decoder with a 2-entry output buffer.
// Ports:
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset
//   bus      : bcd_deci_dec_if.slave (digit in, one-hot decimal out)
//   clr_cnt  : synchronous clear of err_cnt, wins over an increment
//   err_cnt  : saturating count of accepted invalid codes (10-15)
//
// state | meaning
// EMPTY | no buffered entry, outputs forced to zero
// ONE   | head entry in ent0
// FULL  | head in ent0, second entry in ent1, input stalled
module bcd_deci_dec #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  bcd_deci_dec_if.slave    bus,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t      state, state_nxt;
  logic [10:0] ent0, ent1;   // {d, err}
  logic [10:0] dec;
  logic        bad;
  logic        accept, deliver;

  // in_ready comes from registered state only, so a deliver in FULL
  // never opens the input in the same cycle.
  assign bus.in_ready  = (state != FULL);
  assign bus.out_valid = (state != EMPTY);
  assign accept        = bus.in_valid && bus.in_ready;
  assign deliver       = bus.out_valid && bus.out_ready;
  assign {bus.d, bus.err} = (state == EMPTY) ? 11'd0 : ent0;

  always_comb begin
    bad = (bus.bcd > 4'd9);
    dec = 11'd0;
    if (bad) dec = {10'd0, 1'b1};
    else     dec = {10'(1) << bus.bcd, 1'b0};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (accept) state_nxt = ONE;
      ONE: begin
        if (accept && !deliver)      state_nxt = FULL;
        else if (deliver && !accept) state_nxt = EMPTY;
      end
      FULL:    if (deliver) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
  end

  // ent0 is always the head; a deliver out of FULL shifts ent1 forward.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0 <= 11'd0;
      ent1 <= 11'd0;
    end else begin
      case (state)
        EMPTY: if (accept) ent0 <= dec;
        ONE: begin
          if (accept && deliver) ent0 <= dec;
          else if (accept)       ent1 <= dec;
        end
        FULL: if (deliver) ent0 <= ent1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_cnt <= '0;
    else if (clr_cnt)
      err_cnt <= '0;
    else if (accept && bad && (err_cnt != CNT_MAX))
      err_cnt <= err_cnt + CNT_W'(1);
  end

endmodule
